// File: rtl/fifo_enq_arbiter.sv
// Round-robin arbiter sharing one fifo enqueue port among N_P producers, with a
// shadow occupancy count, high-water mark and sticky dequeue-underflow flag.
module fifo_enq_arbiter #(
  parameter int WIDTH_P = 8,
  parameter int CAP_P   = 4,
  parameter int N_P     = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [N_P-1:0]         req_valid_i,
  input  logic [N_P*WIDTH_P-1:0] req_data_i,
  output logic [N_P-1:0]         req_ready_o,
  output logic                   fifo_valid_o,
  output logic [WIDTH_P-1:0]     fifo_data_o,
  input  logic                   fifo_ready_i,
  input  logic                   fifo_deq_i,
  output logic [CAP_P:0]         occupancy_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [CAP_P:0]         peak_o,
  output logic                   err_o
);

  localparam int IDX_W = (N_P > 1) ? $clog2(N_P) : 1;
  localparam int CNT_W = CAP_P + 1;
  localparam logic [CNT_W-1:0] CAP_N = CNT_W'(2 ** CAP_P);

  typedef logic [WIDTH_P-1:0] word_t;

  logic [IDX_W-1:0] ptr_r;
  logic             lock_r;
  logic [IDX_W-1:0] lock_idx_r;
  logic [CNT_W-1:0] occ_r;
  logic [CNT_W-1:0] peak_r;
  logic             err_r;

  logic [IDX_W-1:0] winner_s;
  logic             any_s;
  logic [IDX_W-1:0] sel_s;
  logic             present_s;
  logic             enq_s;
  logic             deq_s;
  logic             full_s;
  logic             empty_s;
  logic [CNT_W-1:0] occ_nxt_s;
  logic [IDX_W-1:0] ptr_nxt_s;
  word_t            word_s;

  // Round-robin scan starting at the priority pointer.
  always_comb begin
    int  c;
    logic hit;
    winner_s = {IDX_W{1'b0}};
    any_s    = 1'b0;
    c        = 0;
    hit      = 1'b0;
    for (int i = 0; i < N_P; i++) begin
      c        = (int'(ptr_r) + i) % N_P;
      hit      = ~any_s & req_valid_i[c];
      winner_s = hit ? IDX_W'(c) : winner_s;
      any_s    = any_s | hit;
    end
  end

  // Grant presentation; a synchronous reset cycle suppresses any pending grant.
  always_comb begin
    full_s    = (occ_r == CAP_N);
    empty_s   = (occ_r == {CNT_W{1'b0}});
    sel_s     = lock_r ? lock_idx_r : winner_s;
    present_s = ~reset_i & (lock_r | (any_s & ~full_s));
    word_s    = req_data_i[sel_s*WIDTH_P +: WIDTH_P];
    enq_s     = present_s & fifo_ready_i;
    deq_s     = fifo_deq_i & ~empty_s;
    ptr_nxt_s = (sel_s == IDX_W'(N_P - 1)) ? {IDX_W{1'b0}} : sel_s + 1'b1;
  end

  // Next shadow occupancy; an accept beyond capacity saturates.
  always_comb begin
    occ_nxt_s = occ_r;
    case ({enq_s, deq_s})
      2'b10:   occ_nxt_s = full_s ? occ_r : occ_r + 1'b1;
      2'b01:   occ_nxt_s = occ_r - 1'b1;
      default: occ_nxt_s = occ_r;
    endcase
  end

  // Arbitration state, occupancy, peak and error registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_r      <= {IDX_W{1'b0}};
      lock_r     <= 1'b0;
      lock_idx_r <= {IDX_W{1'b0}};
      occ_r      <= {CNT_W{1'b0}};
      peak_r     <= {CNT_W{1'b0}};
      err_r      <= 1'b0;
    end else begin
      if (enq_s) begin
        lock_r <= 1'b0;
        ptr_r  <= ptr_nxt_s;
      end else if (present_s) begin
        lock_r     <= 1'b1;
        lock_idx_r <= sel_s;
      end else begin
        lock_r <= lock_r;
      end
      occ_r  <= occ_nxt_s;
      peak_r <= (occ_nxt_s > peak_r) ? occ_nxt_s : peak_r;
      err_r  <= err_r | (fifo_deq_i & empty_s);
    end
  end

  assign fifo_valid_o = present_s;
  assign fifo_data_o  = present_s ? word_s : {WIDTH_P{1'b0}};
  assign req_ready_o  = enq_s ? (N_P'(1'b1) << sel_s) : {N_P{1'b0}};
  assign occupancy_o  = occ_r;
  assign full_o       = full_s;
  assign empty_o      = empty_s;
  assign peak_o       = peak_r;
  assign err_o        = err_r;

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// Directed bench for fifo_enq_arbiter: round-robin order, grant lock, full
// throttling, simultaneous enq/deq, underflow error and reset behaviour.
module tb_fifo_enq_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [3:0]  req_valid_i;
  logic [31:0] req_data_i;
  logic [3:0]  req_ready_o;
  logic        fifo_valid_o;
  logic [7:0]  fifo_data_o;
  logic        fifo_ready_i;
  logic        fifo_deq_i;
  logic [4:0]  occupancy_o;
  logic        full_o;
  logic        empty_o;
  logic [4:0]  peak_o;
  logic        err_o;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_enq_arbiter #(.WIDTH_P(8), .CAP_P(4), .N_P(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .fifo_valid_o(fifo_valid_o), .fifo_data_o(fifo_data_o), .fifo_ready_i(fifo_ready_i),
    .fifo_deq_i(fifo_deq_i), .occupancy_o(occupancy_o), .full_o(full_o),
    .empty_o(empty_o), .peak_o(peak_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next active edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Move to mid-cycle to sample combinational outputs.
  task automatic mid();
    #3;
  endtask

  initial begin
    reset_i      = 1'b1;
    req_valid_i  = 4'b0000;
    req_data_i   = 32'h13121110;
    fifo_ready_i = 1'b1;
    fifo_deq_i   = 1'b0;
    tick();
    tick();
    reset_i = 1'b0;
    mid();
    check_eq("rst_occ", occupancy_o, 32'd0);
    check_eq("rst_peak", peak_o, 32'd0);
    check_eq("rst_err", err_o, 32'd0);
    check_eq("rst_empty", empty_o, 32'd1);
    check_eq("rst_full", full_o, 32'd0);
    check_eq("rst_valid", fifo_valid_o, 32'd0);
    check_eq("rst_ready", req_ready_o, 32'd0);

    // All four requesters: grants 0,1,2,3 in order.
    tick();
    req_valid_i = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      mid();
      check_eq($sformatf("rr_ready%0d", i), req_ready_o, 32'd1 << i);
      check_eq($sformatf("rr_data%0d", i), fifo_data_o, 32'h10 + i);
      tick();
    end
    req_valid_i = 4'b0000;
    check_eq("rr_occ", occupancy_o, 32'd4);
    check_eq("rr_peak", peak_o, 32'd4);

    // Requester 2 locked while fifo stalls; requester 0 joins in cycle 2.
    req_valid_i  = 4'b0100;
    fifo_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      check_eq($sformatf("lock_data%0d", i), fifo_data_o, 32'h12);
      check_eq($sformatf("lock_valid%0d", i), fifo_valid_o, 32'd1);
      check_eq($sformatf("lock_ready%0d", i), req_ready_o, 32'd0);
      tick();
      req_valid_i = 4'b0101;
    end
    fifo_ready_i = 1'b1;
    mid();
    check_eq("lock_accept", req_ready_o, 32'b0100);
    check_eq("lock_accept_data", fifo_data_o, 32'h12);
    tick();
    mid();
    check_eq("wrap_ready", req_ready_o, 32'b0001);
    check_eq("wrap_data", fifo_data_o, 32'h10);
    tick();
    req_valid_i = 4'b0000;
    check_eq("wrap_occ", occupancy_o, 32'd6);

    // One enqueue to reach 7, then enq and deq together.
    req_valid_i = 4'b0010;
    tick();
    check_eq("occ7", occupancy_o, 32'd7);
    fifo_deq_i = 1'b1;
    mid();
    check_eq("both_ready", req_ready_o, 32'b0010);
    tick();
    fifo_deq_i = 1'b0;
    check_eq("both_occ", occupancy_o, 32'd7);
    check_eq("both_peak", peak_o, 32'd7);

    // Fill to capacity.
    req_valid_i = 4'b1111;
    for (int i = 0; i < 9; i++) tick();
    mid();
    check_eq("full_occ", occupancy_o, 32'd16);
    check_eq("full_flag", full_o, 32'd1);
    check_eq("full_valid", fifo_valid_o, 32'd0);
    check_eq("full_ready", req_ready_o, 32'd0);
    check_eq("full_peak", peak_o, 32'd16);
    tick();
    check_eq("full_hold", occupancy_o, 32'd16);
    fifo_deq_i = 1'b1;
    mid();
    check_eq("full_deq_valid", fifo_valid_o, 32'd0);
    tick();
    fifo_deq_i = 1'b0;
    mid();
    check_eq("deq_occ", occupancy_o, 32'd15);
    check_eq("deq_full", full_o, 32'd0);
    check_eq("resume_valid", fifo_valid_o, 32'd1);
    tick();
    req_valid_i = 4'b0000;
    check_eq("refill_occ", occupancy_o, 32'd16);

    // Reset, then underflow with a same-cycle enqueue.
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check_eq("rst2_occ", occupancy_o, 32'd0);
    check_eq("rst2_peak", peak_o, 32'd0);
    req_valid_i = 4'b0010;
    fifo_deq_i  = 1'b1;
    tick();
    req_valid_i = 4'b0000;
    fifo_deq_i  = 1'b0;
    check_eq("uf_err", err_o, 32'd1);
    check_eq("uf_enq_occ", occupancy_o, 32'd1);
    tick();
    check_eq("uf_err_hold", err_o, 32'd1);
    fifo_deq_i = 1'b1;
    tick();
    check_eq("uf_drain", occupancy_o, 32'd0);
    tick();
    fifo_deq_i = 1'b0;
    check_eq("uf_occ0", occupancy_o, 32'd0);
    check_eq("uf_empty", empty_o, 32'd1);
    check_eq("uf_err2", err_o, 32'd1);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check_eq("rst3_err", err_o, 32'd0);
    check_eq("rst3_peak", peak_o, 32'd0);
    req_valid_i = 4'b1111;
    mid();
    check_eq("rst3_ptr", req_ready_o, 32'b0001);
    tick();

    // Reset while locked discards the grant.
    reset_i = 1'b1;
    tick();
    reset_i      = 1'b0;
    req_valid_i  = 4'b1000;
    fifo_ready_i = 1'b0;
    tick();
    reset_i      = 1'b1;
    fifo_ready_i = 1'b1;
    mid();
    check_eq("rstlk_ready", req_ready_o, 32'd0);
    check_eq("rstlk_valid", fifo_valid_o, 32'd0);
    tick();
    reset_i      = 1'b0;
    req_valid_i  = 4'b0001;
    fifo_ready_i = 1'b0;
    mid();
    check_eq("rstlk_occ", occupancy_o, 32'd0);
    check_eq("rstlk_unlock", fifo_data_o, 32'h10);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
